// File: rtl/pixel_conf_sequencer.sv
// Initiator for the per-pixel configuration bus. Takes single or burst
// read/write commands, drives address/data/strobe toward the cores, collects
// readback bytes and returns them on a valid/ready response channel.
module pixel_conf_sequencer #(
    parameter int unsigned WR_PULSE = 2,   // strobe width in clocks (1..7)
    parameter int unsigned RD_LAT   = 3,   // address-to-readback latency (1..7)
    parameter int unsigned MAX_ROW  = 47   // highest core row address
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [11:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_data,
    input  logic [5:0]  i_cmd_len,
    input  logic        i_abort,
    output logic [11:0] o_address_conf_out,
    output logic [7:0]  o_data_conf_wr_out,
    output logic        o_conf_wr_out,
    input  logic [7:0]  i_data_conf_rd_in,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [7:0]  o_rsp_data,
    output logic [11:0] o_rsp_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_STROBE, S_W_HOLD, S_R_WAIT, S_R_RSP, S_FINISH
    } state_t;

    localparam logic [11:0] BCAST_ADDR = 12'hFFF;
    localparam logic [2:0]  WR_LAST    = 3'(WR_PULSE - 1);
    localparam logic [2:0]  RD_LAST    = 3'(RD_LAT - 1);
    localparam logic [5:0]  ROW_MAX    = 6'(MAX_ROW);

    state_t      r_state, w_state_nxt;
    logic [11:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_bcast, w_bcast_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_tick, w_tick_nxt;
    logic [7:0]  r_rsp_data, w_rsp_data_nxt;
    logic [11:0] r_rsp_addr, w_rsp_addr_nxt;
    logic        r_err, w_err_nxt;
    logic        w_wr_phase;

    // Address walk pixel -> region -> row; a row above MAX_ROW just counts on.
    function automatic logic [11:0] next_addr(input logic [11:0] a);
        logic [5:0] row;
        logic [3:0] region;
        logic [1:0] pixel;
        row    = a[11:6];
        region = a[5:2];
        pixel  = a[1:0];
        if (pixel != 2'd3) begin
            pixel = pixel + 2'd1;
        end else begin
            pixel = 2'd0;
            if (region != 4'd15) begin
                region = region + 4'd1;
            end else begin
                region = 4'd0;
                row    = (row == ROW_MAX) ? 6'd0 : row + 6'd1;
            end
        end
        return {row, region, pixel};
    endfunction

    // Next-state and next working-register values for the command sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_bcast_nxt    = r_bcast;
        w_cnt_nxt      = r_cnt;
        w_tick_nxt     = r_tick;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_addr_nxt = r_rsp_addr;
        w_err_nxt      = r_err;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_data_nxt  = i_cmd_data;
                    w_cnt_nxt   = i_cmd_len;
                    w_tick_nxt  = 3'd0;
                    w_bcast_nxt = (i_cmd_addr == BCAST_ADDR);
                    w_err_nxt   = 1'b0;
                    if (i_cmd_write) begin
                        w_addr_nxt  = i_cmd_addr;
                        w_state_nxt = S_W_SETUP;
                    end else if (i_cmd_addr == BCAST_ADDR) begin
                        // Broadcast readback is meaningless on an OR-ed bus.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_addr_nxt  = i_cmd_addr;
                        w_state_nxt = S_R_WAIT;
                    end
                end
            end
            S_W_SETUP: begin
                w_tick_nxt  = 3'd0;
                w_state_nxt = S_W_STROBE;
            end
            S_W_STROBE: begin
                if (r_tick == WR_LAST) w_state_nxt = S_W_HOLD;
                else                   w_tick_nxt  = r_tick + 3'd1;
            end
            S_W_HOLD: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_cnt_nxt   = r_cnt - 6'd1;
                    w_addr_nxt  = r_bcast ? r_addr : next_addr(r_addr);
                    w_state_nxt = S_W_SETUP;
                end
            end
            S_R_WAIT: begin
                if (r_tick == RD_LAST) begin
                    w_rsp_data_nxt = i_data_conf_rd_in;
                    w_rsp_addr_nxt = r_addr;
                    w_state_nxt    = S_R_RSP;
                end else begin
                    w_tick_nxt = r_tick + 3'd1;
                end
            end
            S_R_RSP: begin
                if (i_rsp_ready) begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_cnt_nxt   = r_cnt - 6'd1;
                        w_addr_nxt  = next_addr(r_addr);
                        w_tick_nxt  = 3'd0;
                        w_state_nxt = S_R_WAIT;
                    end
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Abort wins over any beat in flight; the bus address is left where it was.
        if (i_abort && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
            w_state_nxt = S_FINISH;
            w_addr_nxt  = r_addr;
            w_err_nxt   = 1'b1;
        end
    end

    // State and working registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_bcast    <= 1'b0;
            r_cnt      <= '0;
            r_tick     <= '0;
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_bcast    <= w_bcast_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tick     <= w_tick_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_addr <= w_rsp_addr_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign w_wr_phase = (r_state == S_W_SETUP) || (r_state == S_W_STROBE) ||
                        (r_state == S_W_HOLD);

    assign o_cmd_ready        = (r_state == S_IDLE);
    assign o_busy             = (r_state != S_IDLE);
    assign o_address_conf_out = r_addr;
    assign o_data_conf_wr_out = w_wr_phase ? r_data : 8'h00;
    assign o_conf_wr_out      = (r_state == S_W_STROBE);
    assign o_rsp_valid        = (r_state == S_R_RSP);
    assign o_rsp_data         = r_rsp_data;
    assign o_rsp_addr         = r_rsp_addr;
    assign o_done             = (r_state == S_FINISH);
    assign o_err              = (r_state == S_FINISH) && r_err;

endmodule

// File: doc/pixel_conf_sequencer.md
Name: pixel_conf_sequencer

Overview:
Initiator side of the per-pixel configuration bus consumed by the digital core: drives AddressConfIn / DataConfWrIn / ConfWrIn and samples DataConfRdOut readback. Accepts single or burst read/write commands from the global configuration logic. Address auto-increments pixel→region→row. Readback bytes are returned over a valid/ready response channel.

Parameters:
WR_PULSE, 2, width in clocks of ConfWrOut strobe (1..7)
RD_LAT, 3, clocks from address change to valid DataConfRdIn (1..7)
MAX_ROW, 47, highest core row address; row field wraps MAX_ROW→0

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
CmdValid  in  1  command request
CmdReady  out  1  command accepted when CmdValid&CmdReady
CmdWrite  in  1  1=write, 0=read
CmdAddr  in  12  start address {row[11:6], region[5:2], pixel[1:0]}; 12'hFFF = broadcast
CmdData  in  8  write byte (same byte for every burst beat)
CmdLen  in  6  beats minus one (0 → 1 beat, 63 → 64 beats)
Abort  in  1  synchronous abort
AddressConfOut  out  12  address to cores
DataConfWrOut  out  8  write data to cores
ConfWrOut  out  1  write strobe to cores
DataConfRdIn  in  8  OR-ed readback from cores
RspValid  out  1  readback byte valid
RspReady  in  1  response consumer ready
RspData  out  8  readback byte
RspAddr  out  12  address of RspData
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse at command end
Err  out  1  valid with Done: 1 = broadcast read rejected or aborted

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except CmdReady=1; AddressConfOut=0, DataConfWrOut=0.
- CmdReady=1 only in IDLE. Accept latches addr, data, write, len into working regs; beat counter=CmdLen.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT, R_RSP, FINISH.
- Write beat: W_SETUP 1 clk (address+data stable, ConfWrOut=0) → W_STROBE WR_PULSE clks (ConfWrOut=1, addr/data unchanged) → W_HOLD 1 clk (ConfWrOut=0). Beat = WR_PULSE+2 clks.
- Read beat: R_WAIT RD_LAT clks with address driven; at last R_WAIT clk register DataConfRdIn into RspData, RspAddr=current addr → R_RSP: RspValid=1 held until RspReady; RspData/RspAddr stable while RspValid&!RspReady.
- After each beat: counter==0 → FINISH; else counter−1, address increment, next beat (W_SETUP or R_WAIT).
- Increment: pixel+1; pixel 3→0 carries region+1; region 15→0 carries row+1; row MAX_ROW→0 (no carry beyond). Broadcast write does not increment: every beat re-writes 12'hFFF.
- Broadcast read (CmdWrite=0, CmdAddr=12'hFFF): accepted, no bus activity, go straight to FINISH with Err=1.
- FINISH 1 clk: Done=1, Err per outcome; back to IDLE (CmdReady=1 the following clk).
- Abort in any non-IDLE state: next clk ConfWrOut=0, RspValid=0 (pending response dropped), enter FINISH with Err=1. Abort in IDLE ignored. Abort and RspReady handshake in same clk: response counts as delivered, still Err=1.
- DataConfWrOut driven only in write states; returns to 0 in IDLE. AddressConfOut holds last value in IDLE.
- Out-of-range start row (>MAX_ROW) passed through unchanged; wrap applies only on increment.

Test Plan:
- Single write addr 12'h0C5, data 8'hA5, WR_PULSE=2 → ConfWrOut high exactly 2 clks, address/data stable from W_SETUP through W_HOLD, Done at clk 5 after accept, Err=0.
- Write burst CmdLen=5 from 12'h00E (row0,reg3,pix2) → strobed addresses 00E,00F,010,011,012,013; 6 strobes total.
- Read burst CmdLen=3, RD_LAT=3, bench returns addr[7:0]^8'h5A after 3 clks, RspReady low 4 clks on beat 1 → RspData/RspAddr stable while stalled, all 4 bytes correct, in order.
- Row wrap: write CmdLen=1 from {47,15,3}=12'hBFF → second beat address 12'h000.
- Broadcast: write to 12'hFFF CmdLen=2 → 3 strobes at 12'hFFF, Err=0; read at 12'hFFF → no ConfWrOut, Done with Err=1 within 2 clks.
- Abort during W_STROBE of beat 2 and Reset low mid-R_RSP → ConfWrOut low next clk, Done+Err=1; reset clears RspValid immediately, CmdReady=1.
